vx_mem_port_sched: RTL and testbench

- Shares one downstream memory port (e.g. a memory width adapter's input side) between NUM_REQS upstream requesters.
- Arbitrates round-robin and limits outstanding reads per requester with credit counters.
- Appends the requester index to the tag and routes responses back by that index.
- Sits between cache or DMA clients and the memory width adapter / memory bus.

---
 rtl/vx_mem_port_sched_if.sv | 74 +++++++
 rtl/vx_mem_port_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_vx_mem_port_sched.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_mem_port_sched_if.sv
// vx_mem_port_sched_if
//
// Bundles the upstream (requester) and downstream (memory) handshake buses
// of the memory port scheduler.
//
// Modports:
//   slave  : the scheduler's view. It receives requests and memory responses,
//            and drives the grants, the routed responses and the memory request.
//   master : the environment's view (requesters plus memory), the mirror image.
//
// Signals (N = NUM_REQS):
//   req_valid_in/rw_in [N], req_addr_in [N*ADDR], req_byteen_in [N*DATA/8],
//   req_data_in [N*DATA], req_tag_in [N*TAG_IN], req_ready_in [N]
//   rsp_valid_in [N], rsp_data_in [DATA], rsp_tag_in [TAG_IN], rsp_ready_in [N]
//   mem_req_valid/rw/addr/byteen/data/tag [TAG_OUT], mem_req_ready
//   mem_rsp_valid/data/tag [TAG_OUT], mem_rsp_ready
interface vx_mem_port_sched_if #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_IN_WIDTH = 8
);
  localparam int IDX_W         = $clog2(NUM_REQS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_W;
  localparam int BE_W          = DATA_WIDTH / 8;

  logic [NUM_REQS-1:0]              req_valid_in;
  logic [NUM_REQS-1:0]              req_rw_in;
  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in;
  logic [NUM_REQS*BE_W-1:0]         req_byteen_in;
  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in;
  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in;
  logic [NUM_REQS-1:0]              req_ready_in;

  logic [NUM_REQS-1:0]              rsp_valid_in;
  logic [DATA_WIDTH-1:0]            rsp_data_in;
  logic [TAG_IN_WIDTH-1:0]          rsp_tag_in;
  logic [NUM_REQS-1:0]              rsp_ready_in;

  logic                             mem_req_valid;
  logic                             mem_req_rw;
  logic [ADDR_WIDTH-1:0]            mem_req_addr;
  logic [BE_W-1:0]                  mem_req_byteen;
  logic [DATA_WIDTH-1:0]            mem_req_data;
  logic [TAG_OUT_WIDTH-1:0]         mem_req_tag;
  logic                             mem_req_ready;

  logic                             mem_rsp_valid;
  logic [DATA_WIDTH-1:0]            mem_rsp_data;
  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag;
  logic                             mem_rsp_ready;

  modport slave (
    input  req_valid_in, req_rw_in, req_addr_in, req_byteen_in, req_data_in, req_tag_in,
    output req_ready_in,
    output rsp_valid_in, rsp_data_in, rsp_tag_in,
    input  rsp_ready_in,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport master (
    output req_valid_in, req_rw_in, req_addr_in, req_byteen_in, req_data_in, req_tag_in,
    input  req_ready_in,
    input  rsp_valid_in, rsp_data_in, rsp_tag_in,
    output rsp_ready_in,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/vx_mem_port_sched.sv
// vx_mem_port_sched
//
// Shares one downstream memory port between NUM_REQS requesters. Requests are
// arbitrated round-robin into a single-entry output register (one cycle of
// latency, full throughput). Outstanding reads per requester are limited to
// MAX_PENDING by credit counters; writes never consume credit. The requester
// index is appended in the low bits of the downstream tag and used to route
// responses back combinationally.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : vx_mem_port_sched_if.slave, upstream request/response buses and
//            downstream memory request/response buses
//
// Optional feature (macro VX_MEM_SCHED_PERF_EN):
//   perf_stall_cycles  [NUM_REQS*32] : per-requester cycles with valid && !ready
//   perf_credit_stalls [32]          : cycles with any valid read blocked by credit
module vx_mem_port_sched #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_IN_WIDTH = 8,
  parameter int MAX_PENDING  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef VX_MEM_SCHED_PERF_EN
  output logic [NUM_REQS*32-1:0] perf_stall_cycles,
  output logic [31:0]            perf_credit_stalls,
`endif
  vx_mem_port_sched_if.slave     bus
);
  localparam int IDX_W         = $clog2(NUM_REQS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_W;
  localparam int CNT_W         = $clog2(MAX_PENDING + 1);
  localparam int BE_W          = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  generate
    if (NUM_REQS < 2) begin : g_bad_num_reqs
      $error("vx_mem_port_sched: NUM_REQS must be at least 2");
    end
    if (MAX_PENDING < 1) begin : g_bad_max_pending
      $error("vx_mem_port_sched: MAX_PENDING must be at least 1");
    end
  endgenerate

  logic [IDX_W-1:0]         ptr;
  logic [CNT_W-1:0]         pend [NUM_REQS];
  logic [NUM_REQS-1:0]      eligible;
  logic [NUM_REQS-1:0]      pend_zero;
  logic [NUM_REQS-1:0]      pend_full;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_found;
  logic                     load_ok;
  logic                     fire;
  logic [NUM_REQS-1:0]      inc;
  logic [NUM_REQS-1:0]      dec;

  logic                     out_valid;
  logic                     out_rw;
  logic [ADDR_WIDTH-1:0]    out_addr;
  logic [BE_W-1:0]          out_byteen;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [TAG_OUT_WIDTH-1:0] out_tag;

  logic [IDX_W-1:0]         rsp_idx;
  logic                     rsp_in_range;
  logic                     rsp_fire;
  logic [NUM_REQS-1:0]      rsp_valid_vec;
  logic                     rsp_ready_sel;

  // Position `off` steps after `base`, wrapping at NUM_REQS (which need not
  // be a power of two).
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQS) s = s - NUM_REQS;
    return IDX_W'(s);
  endfunction

  // A read is only eligible while its requester still has credit.
  always_comb begin
    eligible  = '0;
    pend_zero = '0;
    pend_full = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      pend_zero[i] = (pend[i] == '0);
      pend_full[i] = (pend[i] >= CNT_MAX);
      eligible[i]  = bus.req_valid_in[i] && (bus.req_rw_in[i] || !pend_full[i]);
    end
  end

  // Round-robin search starting at ptr; the first eligible requester wins.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int j = 0; j < NUM_REQS; j++) begin
      if (!grant_found && eligible[rr_index(ptr, j)]) begin
        grant_idx   = rr_index(ptr, j);
        grant_found = 1'b1;
      end
    end
  end

  // The output register accepts a new entry when empty or draining this cycle.
  // Grants are suppressed while reset is held.
  assign load_ok = !out_valid || bus.mem_req_ready;
  assign fire    = grant_found && load_ok && !reset;

  always_comb begin
    bus.req_ready_in = '0;
    if (fire) bus.req_ready_in[grant_idx] = 1'b1;
  end

  // Output register and round-robin pointer. The payload is held while the
  // memory side back-pressures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_rw     <= 1'b0;
      out_addr   <= '0;
      out_byteen <= '0;
      out_data   <= '0;
      out_tag    <= '0;
      ptr        <= '0;
    end else begin
      if (fire) begin
        out_valid  <= 1'b1;
        out_rw     <= bus.req_rw_in[grant_idx];
        out_addr   <= bus.req_addr_in[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        out_byteen <= bus.req_byteen_in[int'(grant_idx)*BE_W +: BE_W];
        out_data   <= bus.req_data_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        out_tag    <= {bus.req_tag_in[int'(grant_idx)*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
        ptr        <= rr_index(grant_idx, 1);
      end else if (bus.mem_req_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

  assign bus.mem_req_valid  = out_valid;
  assign bus.mem_req_rw     = out_rw;
  assign bus.mem_req_addr   = out_addr;
  assign bus.mem_req_byteen = out_byteen;
  assign bus.mem_req_data   = out_data;
  assign bus.mem_req_tag    = out_tag;

  // Response routing uses the index carried in the low tag bits. With a
  // non-power-of-two NUM_REQS some indices are unused; those responses are
  // accepted and dropped so the memory side cannot lock up.
  assign rsp_idx = bus.mem_rsp_tag[IDX_W-1:0];

  generate
    if ((1 << IDX_W) == NUM_REQS) begin : g_idx_pow2
      assign rsp_in_range = 1'b1;
    end else begin : g_idx_npow2
      assign rsp_in_range = (int'(rsp_idx) < NUM_REQS);
    end
  endgenerate

  always_comb begin
    rsp_valid_vec = '0;
    rsp_ready_sel = 1'b1;
    if (rsp_in_range) begin
      rsp_valid_vec[rsp_idx] = bus.mem_rsp_valid;
      rsp_ready_sel          = bus.rsp_ready_in[rsp_idx];
    end
  end

  assign bus.rsp_valid_in  = rsp_valid_vec;
  assign bus.rsp_data_in   = bus.mem_rsp_data;
  assign bus.rsp_tag_in    = bus.mem_rsp_tag[TAG_OUT_WIDTH-1:IDX_W];
  assign bus.mem_rsp_ready = rsp_ready_sel;
  assign rsp_fire          = bus.mem_rsp_valid && rsp_ready_sel && rsp_in_range;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      inc[i] = fire && !bus.req_rw_in[grant_idx] && (grant_idx == IDX_W'(i));
      dec[i] = rsp_fire && (rsp_idx == IDX_W'(i));
    end
  end

  // Credit counters. Increments only happen for eligible reads, so the count
  // cannot pass MAX_PENDING; a stray decrement at zero is clamped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (inc[i] && !dec[i]) begin
          pend[i] <= pend[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i] && !pend_zero[i]) begin
          pend[i] <= pend[i] - CNT_W'(1);
        end
      end
    end
  end

  a_no_credit_underflow: assert property (@(posedge clk) disable iff (reset)
    !(|(dec & ~inc & pend_zero)))
    else $error("vx_mem_port_sched: response for a requester with no outstanding reads");

  a_rsp_index_in_range: assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_rsp_valid && !rsp_in_range))
    else $error("vx_mem_port_sched: response index out of range, dropped");

`ifdef VX_MEM_SCHED_PERF_EN
  logic [NUM_REQS-1:0][31:0] stall_cnt;
  logic [31:0]               credit_cnt;
  logic                      credit_blocked;

  assign credit_blocked = |(bus.req_valid_in & ~bus.req_rw_in & pend_full);

  // Free-running wrapping counters for stall profiling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      credit_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (bus.req_valid_in[i] && !bus.req_ready_in[i]) stall_cnt[i] <= stall_cnt[i] + 32'd1;
      end
      if (credit_blocked) credit_cnt <= credit_cnt + 32'd1;
    end
  end

  assign perf_stall_cycles  = stall_cnt;
  assign perf_credit_stalls = credit_cnt;
`endif

endmodule

// File: tb/tb_vx_mem_port_sched.sv
// tb_vx_mem_port_sched
//
// Directed bench for vx_mem_port_sched with default parameters
// (4 requesters, 512-bit data, 8-bit upstream tags, 4 credits).
// A table of combinational vectors is checked from the reset state, followed
// by hand-written sequences for round-robin streaming, credit exhaustion,
// back-pressure, same-cycle credit update and reset mid-burst.
module tb_vx_mem_port_sched;
  localparam int NUM_REQS      = 4;
  localparam int DATA_WIDTH    = 512;
  localparam int ADDR_WIDTH    = 26;
  localparam int TAG_IN_WIDTH  = 8;
  localparam int MAX_PENDING   = 4;
  localparam int BE_W          = DATA_WIDTH / 8;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  vx_mem_port_sched_if #(
    .NUM_REQS(NUM_REQS), .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .TAG_IN_WIDTH(TAG_IN_WIDTH)
  ) bus ();

`ifdef VX_MEM_SCHED_PERF_EN
  logic [NUM_REQS*32-1:0] perf_stall_cycles;
  logic [31:0]            perf_credit_stalls;
`endif

  vx_mem_port_sched #(
    .NUM_REQS(NUM_REQS), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .TAG_IN_WIDTH(TAG_IN_WIDTH), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef VX_MEM_SCHED_PERF_EN
    .perf_stall_cycles(perf_stall_cycles),
    .perf_credit_stalls(perf_credit_stalls),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-requester constant payloads.
  function automatic logic [ADDR_WIDTH-1:0] exp_addr(input int i);
    return ADDR_WIDTH'(32'h12340 + i * 32'h111);
  endfunction
  function automatic logic [DATA_WIDTH-1:0] exp_data(input int i);
    return {16{32'hD00D0000 + 32'(i)}};
  endfunction
  function automatic logic [TAG_IN_WIDTH-1:0] exp_tag(input int i);
    return 8'hA0 + 8'(i);
  endfunction
  function automatic logic [BE_W-1:0] exp_byteen(input int i);
    return {8{8'(8'h11 * (i + 1))}};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic [3:0] rw);
    bus.req_valid_in = valid;
    bus.req_rw_in    = rw;
  endtask

  task automatic clear_rsp();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_tag   = '0;
    bus.mem_rsp_data  = '0;
    bus.rsp_ready_in  = '0;
  endtask

  task automatic do_reset();
    apply_stimulus(4'b0000, 4'b0000);
    clear_rsp();
    bus.mem_req_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req_valid;
    logic [3:0] req_rw;
    logic       rsp_valid;
    logic [9:0] rsp_tag;
    logic [3:0] rsp_ready;
    logic [3:0] exp_req_ready;
    logic [3:0] exp_rsp_valid;
    logic [7:0] exp_rsp_tag;
    logic       exp_mem_rsp_ready;
  } vec_t;

  vec_t vecs [6];
  logic [3:0] credit_exp [10];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;

    // Arbitration and response routing from the reset state (ptr 0, no credit used).
    vecs[0] = '{4'b0000, 4'b0000, 1'b0, 10'h000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0};
    vecs[1] = '{4'b0001, 4'b0000, 1'b1, 10'h2A3, 4'b0111, 4'b0001, 4'b1000, 8'hA8, 1'b0};
    vecs[2] = '{4'b1100, 4'b0100, 1'b1, 10'h2A3, 4'b1000, 4'b0100, 4'b1000, 8'hA8, 1'b1};
    vecs[3] = '{4'b1000, 4'b1000, 1'b1, 10'h055, 4'b0010, 4'b1000, 4'b0010, 8'h15, 1'b1};
    vecs[4] = '{4'b1010, 4'b0000, 1'b0, 10'h3FE, 4'b0100, 4'b0010, 4'b0000, 8'hFF, 1'b1};
    vecs[5] = '{4'b1111, 4'b1111, 1'b0, 10'h000, 4'b0000, 4'b0001, 4'b0000, 8'h00, 1'b0};

    // Requester 0 writes, requester 2 reads until its credit runs out.
    credit_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001,
                   4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0001};

    for (int i = 0; i < NUM_REQS; i++) begin
      bus.req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH]       = exp_addr(i);
      bus.req_data_in[i*DATA_WIDTH +: DATA_WIDTH]       = exp_data(i);
      bus.req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH]    = exp_tag(i);
      bus.req_byteen_in[i*BE_W +: BE_W]                 = exp_byteen(i);
    end
    apply_stimulus(4'b1111, 4'b0000);
    clear_rsp();
    bus.mem_req_ready = 1'b1;

    // Reset state, with every requester asking while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_output("reset req_ready", 64'(bus.req_ready_in), 64'h0);
    check_output("reset mem_req_valid", 64'(bus.mem_req_valid), 64'h0);
    check_output("reset mem_req_tag", 64'(bus.mem_req_tag), 64'h0);
    check_output("reset mem_req_addr", 64'(bus.mem_req_addr), 64'h0);
    apply_stimulus(4'b0000, 4'b0000);
    reset = 1'b0;
    tick();

    // Combinational vectors; inputs are withdrawn before each edge.
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].req_valid, vecs[v].req_rw);
      bus.mem_rsp_valid = vecs[v].rsp_valid;
      bus.mem_rsp_tag   = vecs[v].rsp_tag;
      bus.rsp_ready_in  = vecs[v].rsp_ready;
      #1;
      check_output($sformatf("vec%0d req_ready", v), 64'(bus.req_ready_in), 64'(vecs[v].exp_req_ready));
      check_output($sformatf("vec%0d rsp_valid", v), 64'(bus.rsp_valid_in), 64'(vecs[v].exp_rsp_valid));
      check_output($sformatf("vec%0d rsp_tag", v), 64'(bus.rsp_tag_in), 64'(vecs[v].exp_rsp_tag));
      check_output($sformatf("vec%0d mem_rsp_ready", v), 64'(bus.mem_rsp_ready), 64'(vecs[v].exp_mem_rsp_ready));
      apply_stimulus(4'b0000, 4'b0000);
      clear_rsp();
      tick();
    end

    // Continuous reads from all requesters with immediate responses.
    do_reset();
    apply_stimulus(4'b1111, 4'b0000);
    for (int n = 0; n < 8; n++) begin
      bus.mem_rsp_valid = bus.mem_req_valid && !bus.mem_req_rw;
      bus.mem_rsp_tag   = bus.mem_req_tag;
      bus.mem_rsp_data  = bus.mem_req_data;
      bus.rsp_ready_in  = 4'b1111;
      #1;
      check_output($sformatf("rr%0d req_ready", n), 64'(bus.req_ready_in), 64'(4'b0001 << (n % 4)));
      if (n > 0) begin
        check_output($sformatf("rr%0d mem_req_tag", n), 64'(bus.mem_req_tag),
                     64'({exp_tag((n - 1) % 4), 2'((n - 1) % 4)}));
        check_output($sformatf("rr%0d rsp_valid", n), 64'(bus.rsp_valid_in), 64'(4'b0001 << ((n - 1) % 4)));
        check_output($sformatf("rr%0d rsp_tag", n), 64'(bus.rsp_tag_in), 64'(exp_tag((n - 1) % 4)));
        check_output($sformatf("rr%0d rsp_data", n), 64'(bus.rsp_data_in == exp_data((n - 1) % 4)), 64'h1);
      end
      tick();
    end
    apply_stimulus(4'b0000, 4'b0000);
    bus.mem_rsp_valid = bus.mem_req_valid && !bus.mem_req_rw;
    bus.mem_rsp_tag   = bus.mem_req_tag;
    bus.rsp_ready_in  = 4'b1111;
    tick();
    clear_rsp();
    #1;
    for (int i = 0; i < NUM_REQS; i++)
      check_output($sformatf("rr drained pend%0d", i), 64'(dut.pend[i]), 64'h0);

    // Credit exhaustion for requester 2 while requester 0 keeps writing.
    do_reset();
    apply_stimulus(4'b0101, 4'b0001);
    for (int n = 0; n < 10; n++) begin
      #1;
      check_output($sformatf("credit%0d req_ready", n), 64'(bus.req_ready_in), 64'(credit_exp[n]));
      if (n > 0)
        check_output($sformatf("credit%0d mem_req_rw", n), 64'(bus.mem_req_rw),
                     (credit_exp[n-1] == 4'b0001) ? 64'h1 : 64'h0);
      tick();
    end
    check_output("credit pend2 full", 64'(dut.pend[2]), 64'd4);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = {8'h77, 2'd2};
    bus.rsp_ready_in  = 4'b0100;
    #1;
    check_output("credit rsp_valid", 64'(bus.rsp_valid_in), 64'(4'b0100));
    check_output("credit mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'h1);
    check_output("credit still blocked", 64'(bus.req_ready_in), 64'(4'b0001));
    tick();
    clear_rsp();
    #1;
    check_output("credit 5th read issues", 64'(bus.req_ready_in), 64'(4'b0100));
    apply_stimulus(4'b0000, 4'b0000);

    // Back-pressure: a loaded request from requester 1 must hold for 3 cycles.
    do_reset();
    bus.mem_req_ready = 1'b0;
    apply_stimulus(4'b0010, 4'b0000);
    #1;
    check_output("stall load ready", 64'(bus.req_ready_in), 64'(4'b0010));
    tick();
    apply_stimulus(4'b1111, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      #1;
      check_output($sformatf("stall%0d mem_req_valid", s), 64'(bus.mem_req_valid), 64'h1);
      check_output($sformatf("stall%0d mem_req_addr", s), 64'(bus.mem_req_addr), 64'(exp_addr(1)));
      check_output($sformatf("stall%0d mem_req_tag", s), 64'(bus.mem_req_tag), 64'({exp_tag(1), 2'd1}));
      check_output($sformatf("stall%0d mem_req_data", s), 64'(bus.mem_req_data == exp_data(1)), 64'h1);
      check_output($sformatf("stall%0d mem_req_byteen", s), 64'(bus.mem_req_byteen == exp_byteen(1)), 64'h1);
      check_output($sformatf("stall%0d req_ready", s), 64'(bus.req_ready_in), 64'h0);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    check_output("stall release ready", 64'(bus.req_ready_in), 64'(4'b0100));
    apply_stimulus(4'b0000, 4'b0000);
    tick();

    // Same-cycle read fire and response for requester 1 at two credits used.
    do_reset();
    apply_stimulus(4'b0010, 4'b0000);
    tick();
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = {8'h5C, 2'd1};
    bus.rsp_ready_in  = 4'b0010;
    #1;
    check_output("same pend1 before", 64'(dut.pend[1]), 64'd2);
    check_output("same req_ready", 64'(bus.req_ready_in), 64'(4'b0010));
    check_output("same rsp_valid", 64'(bus.rsp_valid_in), 64'(4'b0010));
    check_output("same rsp_tag", 64'(bus.rsp_tag_in), 64'h5C);
    tick();
    apply_stimulus(4'b0000, 4'b0000);
    clear_rsp();
    #1;
    check_output("same pend1 after", 64'(dut.pend[1]), 64'd2);

    // Reset asserted mid-burst.
    do_reset();
    apply_stimulus(4'b1111, 4'b0000);
    tick();
    tick();
    check_output("midrst pre valid", 64'(bus.mem_req_valid), 64'h1);
    check_output("midrst pre pend0", 64'(dut.pend[0]), 64'd1);
    reset = 1'b1;
    #1;
    check_output("midrst mem_req_valid", 64'(bus.mem_req_valid), 64'h0);
    check_output("midrst req_ready", 64'(bus.req_ready_in), 64'h0);
    for (int i = 0; i < NUM_REQS; i++)
      check_output($sformatf("midrst pend%0d", i), 64'(dut.pend[i]), 64'h0);
    tick();
    reset = 1'b0;
    #1;
    check_output("midrst ptr", 64'(dut.ptr), 64'h0);
    check_output("midrst grant after release", 64'(bus.req_ready_in), 64'(4'b0001));
    apply_stimulus(4'b0000, 4'b0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
